muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the EX stage; the RV32M successor to the ALU operation decoder.
- Decodes funct3 for the eight M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Runs a radix-2 shift-add / restoring-divide datapath and raises busy so hazard control can stall the pipeline.
- Ops are issued by the ID/EX control path only when opcode is R-type and funct7 = 0000001.

---
 rtl/muldiv_pkg.sv | 45 ++++
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding, the M-extension funct7 tag and sign helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // funct7 tag that ID decode uses to route R-type ops to this unit
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Helpers work on a fixed wide vector; callers cast in and out, which
  // covers both XLEN operands and 2*XLEN products for XLEN up to 64.
  localparam int unsigned NEG_W = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  // Two's-complement negate when neg is set (also used to take |x|)
  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v,
                                               input logic neg);
    return neg ? (~v + NEG_W'(1)) : v;
  endfunction

  // op_a is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // op_b is treated as signed for MULH, DIV and REM
  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. Magnitudes are
// processed by a radix-2 shift-add multiplier or a restoring divider; signs
// are reapplied in FIX. busy stalls the pipeline while an op is in flight.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [PW-1:0]     acc_q, acc_d;    // product, or remainder:quotient
  logic [XLEN-1:0]   dvs_q, dvs_d;    // multiplicand, or divisor
  logic [XLEN-1:0]   res_q, res_d;
  logic              busy_q, done_q;

  logic              sa_in, sb_in, is_div0, is_ovf;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [PW-1:0]     fprod, p_fix;
  logic [XLEN-1:0]   q_fix, r_fix;
  logic [XLEN:0]     mul_sum, rem_sh, trial;

  // Operand conditioning for a new issue: signedness, magnitudes, special cases
  always_comb begin
    sa_in   = signed_a(funct3) & op_a[XLEN-1];
    sb_in   = signed_b(funct3) & op_b[XLEN-1];
    abs_a   = XLEN'(cond_neg(NEG_W'(op_a), sa_in));
    abs_b   = XLEN'(cond_neg(NEG_W'(op_b), sb_in));
    fprod   = PW'(cond_neg(NEG_W'({{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b}),
                           sa_in ^ sb_in));
    is_div0 = funct3[2] & (op_b == '0);
    is_ovf  = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
  end

  // One iteration step of each datapath plus the sign fix-up of the final values
  always_comb begin
    mul_sum = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    rem_sh  = acc_q[PW-1:XLEN-1];
    trial   = rem_sh - {1'b0, dvs_q};
    p_fix   = PW'(cond_neg(NEG_W'(acc_q), sa_q ^ sb_q));
    q_fix   = XLEN'(cond_neg(NEG_W'(acc_q[XLEN-1:0]), sa_q ^ sb_q));
    r_fix   = XLEN'(cond_neg(NEG_W'(acc_q[PW-1:XLEN]), sa_q));
  end

  // Next-state and datapath update; flush overrides everything at the end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = funct3;
          sa_d  = sa_in;
          sb_d  = sb_in;
          cnt_d = CW'(XLEN - 1);
          dvs_d = funct3[2] ? abs_b : abs_a;
          acc_d = {{XLEN{1'b0}}, (funct3[2] ? abs_a : abs_b)};
          if (is_div0) begin
            res_d   = funct3[1] ? op_a : '1;
            state_d = S_DONE;
          end else if (is_ovf) begin
            res_d   = funct3[1] ? '0 : op_a;
            state_d = S_DONE;
          end else if ((FAST_MUL != 0) && !funct3[2]) begin
            res_d   = (funct3 == F3_MUL) ? fprod[XLEN-1:0] : fprod[PW-1:XLEN];
            state_d = S_DONE;
          end else begin
            state_d = funct3[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DIV: begin
        acc_d = {(trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0]),
                 acc_q[XLEN-2:0], ~trial[XLEN]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (f3_q[2])                res_d = f3_q[1] ? r_fix : q_fix;
        else if (f3_q == F3_MUL)    res_d = p_fix[XLEN-1:0];
        else                        res_d = p_fix[PW-1:XLEN];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      busy_q  <= (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32, iterative multiply): directed ops with
// hand-computed results and latencies, plus a cycle-level reference model
// of busy/done/result compared on every falling edge.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int n_vec = 0;
  int n_mis = 0;

  muldiv_unit #(.XLEN(32), .FAST_MUL(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // RV32M architectural result from plain signed/unsigned arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    r  = '0;
    case (f3)
      F3_MUL:    begin p = sa * sb; r = p[31:0];  end
      F3_MULH:   begin p = sa * sb; r = p[63:32]; end
      F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
      F3_MULHU:  begin p = ua * ub; r = p[63:32]; end
      F3_DIV:    begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit ref_special(input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference model: an accepted op shows busy for 33 cycles then done, or
  // done immediately when it is a special case; flush aborts silently.
  logic        m_busy, m_done;
  logic [31:0] m_res, m_exp;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_exp  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_busy <= 1'b0;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_res  <= m_exp;
        end
        m_left <= m_left - 1;
      end else if (!m_done && start) begin
        m_exp <= ref_result(funct3, op_a, op_b);
        if (ref_special(funct3, op_a, op_b)) begin
          m_done <= 1'b1;
          m_res  <= ref_result(funct3, op_a, op_b);
        end else begin
          m_busy <= 1'b1;
          m_left <= 33;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model busy",   {31'b0, busy}, {31'b0, m_busy});
      chk("model done",   {31'b0, done}, {31'b0, m_done});
      chk("model result", result, m_res);
    end
  end

  task automatic wait_done(input string nm, input logic [31:0] exp_res, input int exp_lat);
    int lat, nbusy;
    bit seen;
    lat = 0; nbusy = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    chk({nm, " done seen"}, {31'b0, seen}, 32'd1);
    chk({nm, " result"}, result, exp_res);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " busy cycles"}, 32'(nbusy), (exp_lat == 34) ? 32'd33 : 32'd0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    issue(f3, a, b);
    wait_done(nm, exp_res, exp_lat);
  endtask

  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t extra[6];

  initial begin
    int ndone;
    extra[0] = '{F3_MULHU,  32'h1234_5678, 32'h9ABC_DEF0};
    extra[1] = '{F3_MULH,   32'hFFFF_FFFB, 32'h0001_E240};
    extra[2] = '{F3_DIV,    32'h8000_0000, 32'h0000_0003};
    extra[3] = '{F3_REM,    32'hFFFF_FF9C, 32'hFFFF_FFF9};
    extra[4] = '{F3_DIVU,   32'hFFFF_FFFF, 32'h0000_0010};
    extra[5] = '{F3_MUL,    32'hDEAD_BEEF, 32'h0000_0001};

    repeat (3) @(negedge clk);
    chk("reset busy",   {31'b0, busy}, 32'd0);
    chk("reset done",   {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    #2 rst_n = 1'b1;

    run_op("MUL 7*-3",        F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("MULH min*min",    F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("MULHSU -1*max",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("MULHU max*max",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("DIV -7/2",        F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("REM -7/2",        F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("REM 7/-2",        F3_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34);
    run_op("DIVU 100/7",      F3_DIVU,   32'd100,       32'd7,         32'd14,        34);
    run_op("DIV 5/0",         F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("REMU 5/0",        F3_REMU,   32'd5,         32'd0,         32'd5,         1);
    run_op("DIV ovf",         F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",         F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    foreach (extra[i])
      run_op("extra", extra[i].f3, extra[i].a, extra[i].b,
             ref_result(extra[i].f3, extra[i].a, extra[i].b),
             ref_special(extra[i].f3, extra[i].a, extra[i].b) ? 1 : 34);

    run_op("REMU 100/7",      F3_REMU,   32'd100,       32'd7,         32'd2,         34);

    // Flush sampled at edge k+10 of a DIV, together with a start that must lose
    issue(F3_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1; start = 1'b1; funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk);
    #1 flush = 1'b0; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    chk("flush busy",   {31'b0, busy}, 32'd0);
    chk("flush done",   {31'b0, done}, 32'd0);
    chk("flush result", result, 32'd2);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("reissue DIVU", 32'd14, 34);

    // start held high through busy and done: exactly one op completes
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk);
    #1 funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd3;
    wait_done("start while busy", 32'hFFFF_FFEB, 34);
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("no second op", 32'(ndone), 32'd0);

    // Asynchronous reset in the middle of a multiply
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy",   {31'b0, busy}, 32'd0);
    chk("async rst done",   {31'b0, done}, 32'd0);
    chk("async rst result", result, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op("MUL after reset", F3_MUL, 32'd5, 32'd6, 32'd30, 34);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
